// File: rtl/pso_pulse_gen.sv
// Internal encoder/PSO pulse generator: registered count_enable_x pulse train with
// programmable gap, high width, burst length and an optional sawtooth gap ramp.
module pso_pulse_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk48mhz,
    input  logic             rstn,
    input  logic             enable,
    input  logic             start_pulse,
    input  logic             stop,
    input  logic [CNT_W-1:0] period_reg,
    input  logic [7:0]       width_reg,
    input  logic [15:0]      ramp_step_reg,
    input  logic [7:0]       ramp_len_reg,
    input  logic [CNT_W-1:0] burst_reg,
    output logic             count_enable_x,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_count
);

    typedef enum logic [1:0] {IDLE, GAP, HIGH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] period_q, burst_q;
    logic [7:0]       width_q, ramp_len_q, ramp_idx_q, ramp_idx_nxt;
    logic [15:0]      ramp_step_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt, pc_nxt;
    logic             done_nxt;
    logic             abort, start_ok, ramp_on, burst_end;
    logic [23:0]      ramp_prod;
    logic [CNT_W:0]   gap_sum;
    logic [CNT_W-1:0] gap;

    assign abort    = stop || !enable;
    assign start_ok = start_pulse && enable && !stop;
    assign ramp_on  = ramp_len_q > 8'd1;

    // Gap for the current pulse, one bit wider than the datapath so overflow saturates.
    assign ramp_prod = ramp_step_q * ramp_idx_q;
    assign gap_sum   = {1'b0, period_q} + (CNT_W+1)'(ramp_prod);
    assign gap       = gap_sum[CNT_W] ? {CNT_W{1'b1}} : gap_sum[CNT_W-1:0];

    assign burst_end = (burst_q != '0) && (pulse_count == burst_q);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt_q;
        ramp_idx_nxt = ramp_idx_q;
        pc_nxt       = pulse_count;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt    = GAP;
                    cnt_nxt      = CNT_W'(1);
                    ramp_idx_nxt = '0;
                    pc_nxt       = '0;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt_q == gap) begin
                    state_nxt = HIGH;
                    cnt_nxt   = CNT_W'(1);
                    pc_nxt    = pulse_count + CNT_W'(1);
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                // Abort is tested first so it wins over burst completion on the same edge.
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt_q == CNT_W'(width_q)) begin
                    if (burst_end) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt    = GAP;
                        cnt_nxt      = CNT_W'(1);
                        ramp_idx_nxt = (!ramp_on || ramp_idx_q == ramp_len_q - 8'd1)
                                       ? 8'd0 : ramp_idx_q + 8'd1;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; every output is a flop.
    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt_q          <= '0;
            ramp_idx_q     <= '0;
            pulse_count    <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            count_enable_x <= 1'b0;
            period_q       <= '0;
            burst_q        <= '0;
            width_q        <= '0;
            ramp_len_q     <= '0;
            ramp_step_q    <= '0;
        end else begin
            state          <= state_nxt;
            cnt_q          <= cnt_nxt;
            ramp_idx_q     <= ramp_idx_nxt;
            pulse_count    <= pc_nxt;
            done           <= done_nxt;
            busy           <= (state_nxt != IDLE);
            count_enable_x <= (state_nxt == HIGH);
            if (state == IDLE && start_ok) begin
                period_q    <= (period_reg == '0) ? CNT_W'(1) : period_reg;
                width_q     <= (width_reg == 8'd0) ? 8'd1 : width_reg;
                burst_q     <= burst_reg;
                ramp_len_q  <= ramp_len_reg;
                ramp_step_q <= ramp_step_reg;
            end
        end
    end

endmodule

// File: tb/tb_pso_pulse_gen.sv
// Directed self-checking bench for pso_pulse_gen: edge-numbered rise/done/busy
// timing against hand-computed schedules.
module tb_pso_pulse_gen;

    logic        clk48mhz = 1'b0;
    logic        rstn;
    logic        enable;
    logic        start_pulse;
    logic        stop;
    logic [31:0] period_reg;
    logic [7:0]  width_reg;
    logic [15:0] ramp_step_reg;
    logic [7:0]  ramp_len_reg;
    logic [31:0] burst_reg;
    logic        count_enable_x;
    logic        busy;
    logic        done;
    logic [31:0] pulse_count;

    int checks = 0;
    int errors = 0;

    int rises[$];
    int done_at, done_cnt, busy_fall, last_fall;

    pso_pulse_gen #(.CNT_W(32)) dut (
        .clk48mhz      (clk48mhz),
        .rstn          (rstn),
        .enable        (enable),
        .start_pulse   (start_pulse),
        .stop          (stop),
        .period_reg    (period_reg),
        .width_reg     (width_reg),
        .ramp_step_reg (ramp_step_reg),
        .ramp_len_reg  (ramp_len_reg),
        .burst_reg     (burst_reg),
        .count_enable_x(count_enable_x),
        .busy          (busy),
        .done          (done),
        .pulse_count   (pulse_count)
    );

    always #5 clk48mhz = ~clk48mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [31:0] p, input logic [7:0] w, input logic [15:0] st,
                       input logic [7:0] ln, input logic [31:0] b);
        period_reg    = p;
        width_reg     = w;
        ramp_step_reg = st;
        ramp_len_reg  = ln;
        burst_reg     = b;
    endtask

    // Start at edge 0, then record events per edge until busy falls or the budget expires.
    task automatic run(input int budget, input int stop_edge, input int restart_edge);
        logic prev_cen;
        rises.delete();
        done_at   = -1;
        done_cnt  = 0;
        busy_fall = -1;
        last_fall = -1;
        @(negedge clk48mhz);
        start_pulse = 1'b1;
        @(posedge clk48mhz);
        #1 start_pulse = 1'b0;
        check("busy_after_edge0", busy, 1);
        prev_cen = count_enable_x;
        for (int e = 1; e <= budget; e++) begin
            stop        = (e == stop_edge);
            start_pulse = (e == restart_edge);
            @(posedge clk48mhz);
            #1;
            stop        = 1'b0;
            start_pulse = 1'b0;
            if (count_enable_x && !prev_cen) rises.push_back(e);
            if (!count_enable_x && prev_cen) last_fall = e;
            if (done) begin
                done_cnt++;
                done_at = e;
            end
            prev_cen = count_enable_x;
            if (!busy) begin
                busy_fall = e;
                break;
            end
        end
    endtask

    task automatic check_rises(input string tag, input int exp_q[$]);
        check({tag, "_n_rises"}, rises.size(), exp_q.size());
        foreach (exp_q[i]) begin
            int got;
            got = (i < rises.size()) ? rises[i] : -1;
            check($sformatf("%s_rise%0d", tag, i), got, exp_q[i]);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        enable      = 1'b1;
        start_pulse = 1'b0;
        stop        = 1'b0;
        cfg(32'd4, 8'd1, 16'd0, 8'd0, 32'd3);
        #1;
        check("rst_cen", count_enable_x, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pc", pulse_count, 0);
        repeat (2) @(posedge clk48mhz);
        #2 rstn = 1'b1;

        // Basic burst
        run(40, -1, -1);
        check_rises("basic", '{4, 9, 14});
        check("basic_done_at", done_at, 15);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_busy_fall", busy_fall, 15);
        check("basic_last_fall", last_fall, 15);
        check("basic_pc", pulse_count, 3);
        repeat (2) @(posedge clk48mhz);
        #1;
        check("basic_pc_held", pulse_count, 3);
        check("basic_done_one_cycle", done, 0);

        // Ignored start during the run
        run(40, -1, 6);
        check_rises("ign", '{4, 9, 14});
        check("ign_done_at", done_at, 15);
        check("ign_pc", pulse_count, 3);

        // Sawtooth ramp
        cfg(32'd4, 8'd1, 16'd1, 8'd3, 32'd4);
        run(60, -1, -1);
        check_rises("saw", '{4, 10, 17, 22});
        check("saw_done_at", done_at, 23);
        check("saw_pc", pulse_count, 4);

        // Clamps
        cfg(32'd0, 8'd0, 16'd0, 8'd0, 32'd2);
        run(20, -1, -1);
        check_rises("clamp", '{1, 3});
        check("clamp_done_at", done_at, 4);

        // Abort in the third HIGH phase (rises 10, 22, 34; high over 34..35)
        cfg(32'd10, 8'd2, 16'd0, 8'd0, 32'd0);
        run(80, 35, -1);
        check_rises("abort", '{10, 22, 34});
        check("abort_busy_fall", busy_fall, 35);
        check("abort_cen_fall", last_fall, 35);
        check("abort_no_done", done_cnt, 0);
        check("abort_pc", pulse_count, 3);

        // Start with stop high, and with enable low, must be ignored
        @(negedge clk48mhz);
        start_pulse = 1'b1;
        stop        = 1'b1;
        @(posedge clk48mhz);
        #1 start_pulse = 1'b0;
        stop = 1'b0;
        check("start_stop_ign_busy", busy, 0);
        check("start_stop_ign_pc", pulse_count, 3);
        @(negedge clk48mhz);
        start_pulse = 1'b1;
        enable      = 1'b0;
        @(posedge clk48mhz);
        #1 start_pulse = 1'b0;
        enable = 1'b1;
        check("start_dis_ign_busy", busy, 0);

        // Reset mid-run, in GAP after the first pulse
        run(15, -1, -1);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_pc", pulse_count, 1);
        #3 rstn = 1'b0;
        #1;
        check("mid_rst_cen", count_enable_x, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pc", pulse_count, 0);
        #2 rstn = 1'b1;
        cfg(32'd2, 8'd1, 16'd0, 8'd0, 32'd1);
        run(20, -1, -1);
        check_rises("post_rst", '{2});
        check("post_rst_done_at", done_at, 3);
        check("post_rst_pc", pulse_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pso_pulse_gen.md
# pso_pulse_gen

Internal encoder/PSO pulse generator: the source end of the `count_enable_x` interface that `Master_State` consumes when `ext_encoder` is low. It produces a train of registered `count_enable_x` pulses with a programmable gap, high width and burst length. An optional sawtooth ramp of the gap exercises column timing without external motion hardware. It sits beside `Master_State` in the same 48 MHz domain, driven from the same register bank.

## Interface
- `CNT_W`, 32, width of period, burst and pulse-count datapath
- `clk48mhz`  in  1  system clock, all logic on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `enable`  in  1  generator enable; low forces stop
- `start_pulse`  in  1  single-cycle start request
- `stop`  in  1  abort request, level-sensitive
- `period_reg`  in  CNT_W  base low gap in clocks
- `width_reg`  in  8  high width in clocks
- `ramp_step_reg`  in  16  gap increment per pulse within a sawtooth
- `ramp_len_reg`  in  8  pulses per sawtooth cycle
- `burst_reg`  in  CNT_W  pulses per run; 0 means continuous
- `count_enable_x`  out  1  generated pulse train, registered
- `busy`  out  1  high from accepted start until the run ends
- `done`  out  1  single-cycle pulse when a burst completes normally
- `pulse_count`  out  CNT_W  rising edges issued in the current or last run

## Operation
- States: IDLE, GAP, HIGH.
- **IDLE**
  - `start_pulse && enable` moves to GAP.
  - Latches all `*_reg` inputs and clears `pulse_count`, `k`, and `ramp_idx`.
  - Register changes during a run are ignored.
- **Clamps at latch**
  - `period_reg==0` is treated as 1.
  - `width_reg==0` is treated as 1.
  - `ramp_len_reg<=1` disables the ramp, so every gap equals the base gap.
- **Gap for pulse k**
  - I_k = period + ramp_step*(k mod ramp_len).
  - Computed in CNT_W+1 bits, saturating at 2^CNT_W−1.
  - `ramp_idx` wraps from ramp_len−1 to 0.
- **GAP**
  - Counts I_k clocks with `count_enable_x` low, then moves to HIGH.
  - `count_enable_x` rises and `pulse_count` increments on the same edge.
- **HIGH**
  - Holds `count_enable_x` high for W clocks.
  - If the burst is non-zero and `pulse_count==burst`: goes to IDLE, `count_enable_x` falls, `done`=1 for one cycle, `busy` falls.
  - Otherwise: k advances and the block returns to GAP.
- **Continuous mode** (burst 0): `pulse_count` wraps from 2^CNT_W−1 to 0 without stopping.
- **Abort**: `stop` high or `enable` low in GAP/HIGH sends the block to IDLE at the next edge.
  - `count_enable_x`=0 and `busy`=0.
  - No `done`; `pulse_count` holds.
- **Precedence**: abort beats burst completion on the same edge, so no `done` is issued.
- `start_pulse` while busy is ignored.
- `start_pulse` together with `stop`, or with `enable` low, is ignored.
- **Reset**: asynchronous, at any time including mid-run.
  - State goes to IDLE.
  - `count_enable_x`=0, `busy`=0, `done`=0, `pulse_count`=0.
  - Latched registers and ramp index are cleared.

## Timing
- Edge 0 is the edge that samples `start_pulse`; `busy`=1 after edge 0.
- First rise of `count_enable_x` is at edge I_0, and it falls at edge I_0+W.
- Rise n+1 occurs at rise n + W + I_(n+1).
- Rise-to-rise spacing is W+I_k, with a minimum of 2 clocks.
- `done` and `busy` fall on the same edge as the final fall of `count_enable_x`.
- A new start is accepted at the earliest one edge after `done`.
- Abort latency is one clock.
- All outputs come directly from flops, with no combinational paths from inputs.

## Test plan
- **Basic burst**: period=4, W=1, ramp_len=0, burst=3, start at edge 0.
  - Rises at edges 4, 9, 14; final fall and `done` at 15.
  - `pulse_count`=3 and held; `busy` high over edges 1–15.
- **Sawtooth**: period=4, step=1, ramp_len=3, W=1, burst=4.
  - Gaps 4, 5, 6, 4; rises at 4, 10, 17, 22; `done` at 23.
- **Clamp**: period=0, W=0, burst=2.
  - Rises at 1 and 3; `done` at 4.
- **Abort**: continuous mode with period=10, W=2; assert `stop` during the 3rd HIGH phase.
  - `count_enable_x` low next edge, `busy`=0, no `done`, `pulse_count`=3.
- **Reset mid-run**: deassert `rstn` asynchronously in GAP.
  - All outputs 0 immediately.
  - After release, a start with burst=1, period=2, W=1 gives a rise at 2 and `done` at 3.
- **Ignored start**: pulse `start_pulse` at edge 6 of the basic-burst run.
  - Timing is identical to the basic burst.
  - `pulse_count` is not cleared.
